mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: FAIR, default 1; 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 Port: req0_a, req0_b  input  4 each  requester 0 unsigned operands.
REQ-006 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 Port: req1_valid, req1_a, req1_b, req1_ready  same widths and directions as requester 0, for requester 1.
REQ-008 Port: res_valid  output  1  result held on res_p/res_id.
REQ-009 Port: res_p  output  8  unsigned product.
REQ-010 Port: res_id  output  1  requester that owns res_p (0 or 1).
REQ-011 Port: res_ready  input  1  consumer accepts the result.
REQ-012 The block SHALL contain exactly one instance of the team's 4-bit combinational multiplier, shared by both requesters.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE with no valid request, the FSM SHALL remain in IDLE with both readies low.
REQ-015 In IDLE with at least one valid, the block SHALL assert reqN_ready combinationally for exactly one granted requester.
REQ-016 On that edge the block SHALL latch a, b and the grant id, update last_grant, and move to CALC.
REQ-017 reqN_ready SHALL be low in CALC and DONE and for a non-granted requester; a handshake completes only when valid and ready are both high.
REQ-018 Grant with one valid: the block SHALL grant that requester.
REQ-019 Grant with both valid, FAIR=1: the block SHALL grant the requester not in last_grant.
REQ-020 Grant with both valid, FAIR=0: the block SHALL always grant requester 0.
REQ-021 In CALC the block SHALL register the multiplier output into res_p and the latched id into res_id, then move to DONE; CALC SHALL last exactly one cycle.
REQ-022 In DONE, res_valid SHALL be 1; res_p and res_id SHALL stay stable until the handshake.
REQ-023 In DONE with res_ready=1, the FSM SHALL move to IDLE and res_valid SHALL drop on the next cycle.
REQ-024 In DONE with res_ready=0, the FSM SHALL remain in DONE indefinitely; no new request SHALL be accepted.
REQ-025 Latency: if the request is accepted at edge N, res_valid SHALL be 1 from edge N+2; minimum issue interval is 3 cycles.
REQ-026 Arithmetic: res_p SHALL equal a*b as unsigned 8-bit, full range 0..225 with no truncation (15*15 = 225 = 8'hE1).
REQ-027 Requester operand changes after acceptance SHALL NOT affect the in-flight result.
REQ-028 A requester deasserting valid while not granted SHALL be treated as withdrawn, with no side effect.

Reset
REQ-029 On an edge with rst=1, the block SHALL set the state to IDLE, res_valid=0, res_p=8'h00, res_id=0, and last_grant=1, so requester 0 wins the first contended grant.
REQ-030 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-031 Reset in CALC or DONE SHALL discard the in-flight result; res_valid SHALL be 0 on the cycle after the reset edge.

Verification
REQ-032 Single request: req0 a=3, b=5, res_ready=1 -> req0_ready high one cycle; 2 cycles later res_valid=1, res_p=15, res_id=0.
REQ-033 Contention, FAIR=1: both valid (req0 7*9, req1 15*15) held continuously from reset -> results in order id0 res_p=63, id1 res_p=225, id0 res_p=63.
REQ-034 Fixed priority, FAIR=0: both valid held -> every grant goes to id0 and req1_ready stays 0.
REQ-035 Backpressure: res_ready=0 for 10 cycles after res_valid -> res_p stable, both readies 0; raise res_ready -> res_valid drops next cycle and a new grant follows.
REQ-036 Reset mid-operation: assert rst in CALC -> next cycle res_valid=0, res_p=0, and the next contended grant goes to requester 0.
REQ-037 Exhaustive: all 256 (a,b) pairs, alternating requesters -> res_p equals a*b and res_id equals the issuer for every transaction.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//   Two requesters share one 4x4 unsigned multiplier. One request is accepted
//   at a time. The operands are latched, the product is registered one cycle
//   later, and the result is then held until the consumer takes it.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for a request; grant and ready are combinational
//   CALC  | latched operands drive the multiplier; product is registered
//   DONE  | result held on res_p/res_id until res_ready
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/_a/_b/_ready   requester N operand handshake (N = 0, 1)
//   res_valid/_p/_id/_ready   result handshake; res_id names the owner
// Parameter
//   FAIR  1 = round-robin between contending requesters,
//         0 = requester 0 always wins
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       res_valid,
    output logic [7:0] res_p,
    output logic       res_id,
    input  logic       res_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_id;
    logic       r_last_grant;
    logic [7:0] r_res_p;
    logic       r_res_id;

    logic       w_grant_id;
    logic       w_accept;
    logic [7:0] w_prod;

    // The single shared multiplier only ever sees the latched operands, so
    // requesters may change their inputs freely once accepted.
    mult4 u_mult4 (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // Grant selection. Only meaningful when at least one valid is high.
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = (FAIR != 0) ? ~r_last_grant : 1'b0;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ready is gated by rst so no handshake can complete on a
                // reset edge.
                if (!rst && (req0_valid || req1_valid)) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= 4'h0;
            r_b          <= 4'h0;
            r_id         <= 1'b0;
            // Starting at 1 lets requester 0 win the first contended grant.
            r_last_grant <= 1'b1;
            r_res_p      <= 8'h00;
            r_res_id     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a          <= w_grant_id ? req1_a : req0_a;
                r_b          <= w_grant_id ? req1_b : req0_b;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == S_CALC) begin
                r_res_p  <= w_prod;
                r_res_id <= r_id;
            end
        end
    end

    assign res_p  = r_res_p;
    assign res_id = r_res_id;

endmodule

// ---------------------------------------------------------------------------
// mult4
//   4x4 unsigned combinational multiplier, full 8-bit product.
// Ports
//   i_a, i_b  operands
//   o_p       product
// ---------------------------------------------------------------------------
module mult4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    assign o_p = {4'h0, i_a} * {4'h0, i_b};

endmodule

// File: tb/tb_mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Drives a round-robin (f_) and a fixed-priority (p_) instance from the same
//   stimulus. Inputs change 1 time unit after the rising edge; outputs are
//   sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req1_valid;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       res_ready;

    logic       f_req0_ready, f_req1_ready, f_res_valid, f_res_id;
    logic [7:0] f_res_p;
    logic       p_req0_ready, p_req1_ready, p_res_valid, p_res_id;
    logic [7:0] p_res_p;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.FAIR(1)) u_dut_fair (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (f_req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (f_req1_ready),
        .res_valid  (f_res_valid),
        .res_p      (f_res_p),
        .res_id     (f_res_id),
        .res_ready  (res_ready)
    );

    mult_share_arbiter #(.FAIR(0)) u_dut_prio (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (p_req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (p_req1_ready),
        .res_valid  (p_res_valid),
        .res_p      (p_res_p),
        .res_id     (p_res_id),
        .res_ready  (res_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with both valids low and the DUTs idle.
    // Returns just after the accepting edge, with operands scrambled.
    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
        bit got;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((id == 0 && f_req0_ready) || (id == 1 && f_req1_ready)) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_val("grant_seen", 32'(got), 32'd1);
        check_val("other_ready_low", 32'(id == 0 ? f_req1_ready : f_req0_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    endtask

    // Called just after the accepting edge; checks CALC then DONE and leaves
    // just after the edge following DONE.
    task automatic collect(input logic [7:0] exp_p, input logic exp_id);
        @(negedge clk);
        check_val("calc_res_valid", 32'(f_res_valid), 32'd0);
        @(negedge clk);
        check_val("done_res_valid", 32'(f_res_valid), 32'd1);
        check_val("res_p", 32'(f_res_p), 32'(exp_p));
        check_val("res_id", 32'(f_res_id), 32'(exp_id));
        check_val("prio_res_p", 32'(p_res_p), 32'(exp_p));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [7:0] exp_cont [3];
        exp_cont[0] = 8'd63; exp_cont[1] = 8'd225; exp_cont[2] = 8'd63;

        // Reset with both requesters already contending.
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd7;  req0_b = 4'd9;
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_f_req0_ready", 32'(f_req0_ready), 32'd0);
        check_val("rst_f_req1_ready", 32'(f_req1_ready), 32'd0);
        check_val("rst_p_req0_ready", 32'(p_req0_ready), 32'd0);
        check_val("rst_res_valid", 32'(f_res_valid), 32'd0);
        check_val("rst_res_p", 32'(f_res_p), 32'd0);
        check_val("rst_res_id", 32'(f_res_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: round-robin 0,1,0; fixed priority always 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("cont_f_req0_ready", 32'(f_req0_ready), 32'(i % 2 == 0));
            check_val("cont_f_req1_ready", 32'(f_req1_ready), 32'(i % 2 == 1));
            check_val("cont_p_req0_ready", 32'(p_req0_ready), 32'd1);
            check_val("cont_p_req1_ready", 32'(p_req1_ready), 32'd0);
            @(negedge clk);
            check_val("cont_calc_ready", 32'({f_req0_ready, f_req1_ready}), 32'd0);
            check_val("cont_calc_valid", 32'(f_res_valid), 32'd0);
            @(negedge clk);
            check_val("cont_res_valid", 32'(f_res_valid), 32'd1);
            check_val("cont_res_p", 32'(f_res_p), 32'(exp_cont[i]));
            check_val("cont_res_id", 32'(f_res_id), 32'(i % 2));
            check_val("cont_done_ready", 32'({f_req0_ready, f_req1_ready}), 32'd0);
            check_val("cont_p_res_p", 32'(p_res_p), 32'd63);
            check_val("cont_p_res_id", 32'(p_res_id), 32'd0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Single request 3*5.
        issue(0, 4'd3, 4'd5);
        collect(8'd15, 1'b0);
        @(negedge clk);
        check_val("idle_res_valid", 32'(f_res_valid), 32'd0);
        @(posedge clk); #1;

        // Backpressure: hold 6*7 for 10 more cycles with req0 waiting.
        res_ready = 1'b0;
        issue(1, 4'd6, 4'd7);
        @(negedge clk);
        check_val("bp_calc_valid", 32'(f_res_valid), 32'd0);
        @(negedge clk);
        check_val("bp_done_valid", 32'(f_res_valid), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_hold_valid", 32'(f_res_valid), 32'd1);
            check_val("bp_hold_p", 32'(f_res_p), 32'd42);
            check_val("bp_hold_id", 32'(f_res_id), 32'd1);
            check_val("bp_hold_ready", 32'({f_req0_ready, f_req1_ready}), 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release_valid", 32'(f_res_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("bp_after_valid", 32'(f_res_valid), 32'd0);
        check_val("bp_new_grant", 32'(f_req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
        collect(8'd16, 1'b0);

        // Reset during CALC; last grant was 0, reset must restore 1.
        issue(0, 4'd9, 4'd9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        @(negedge clk);
        check_val("mid_rst_valid", 32'(f_res_valid), 32'd0);
        check_val("mid_rst_p", 32'(f_res_p), 32'd0);
        check_val("mid_rst_id", 32'(f_res_id), 32'd0);
        check_val("mid_rst_req0_ready", 32'(f_req0_ready), 32'd1);
        check_val("mid_rst_req1_ready", 32'(f_req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        collect(8'd12, 1'b0);

        // Exhaustive operand sweep, alternating requesters.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int id;
                id = (a * 16 + b) % 2;
                issue(id, a[3:0], b[3:0]);
                collect(8'(a * b), id[0]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
